// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle control unit for the 16-bit accumulator ISA. It fetches an
// instruction, decodes it, optionally reads a data-memory operand, presents
// the operands to an external combinational ALU, consumes the ALU result and
// flags, and optionally writes a result back to data memory. The unit owns
// the program counter, the W register and the carry/zero flags. It never
// does arithmetic itself; every result and flag comes from the ALU.
//
// Instruction word: [15:12] opcode, [11] d (0: result to W, 1: to memory),
//                   [10:0] address or literal.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   instr_addr  -> imem        instruction address (always equals pc)
//   instr_data  <- imem        instruction word, one cycle after instr_addr
//   data_addr   -> dmem        operand address (ir[10:0])
//   data_rdata  <- dmem        read data, valid while data_ready is high
//   data_ready  <- dmem        read-data-valid / write-complete handshake
//   data_we     -> dmem        write strobe, held until data_ready
//   data_wdata  -> dmem        write data
//   alu_op      -> ALU         opcode during EXEC, 4'hF otherwise
//   alu_mem     -> ALU         latched memory operand (mdr)
//   alu_wreg    -> ALU         W register operand
//   alu_carry_in/alu_zero_in   current architectural flags
//   alu_result, alu_carry_out, alu_zero_out, alu_pc_skip  <- ALU
//   wreg, pc, halted           architectural state / status
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [15:0]       instr_data,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [15:0]       data_rdata,
  input  logic              data_ready,
  output logic              data_we,
  output logic [15:0]       data_wdata,
  output logic [3:0]        alu_op,
  output logic [15:0]       alu_mem,
  output logic [15:0]       alu_wreg,
  output logic              alu_carry_in,
  output logic              alu_zero_in,
  input  logic [15:0]       alu_result,
  input  logic              alu_carry_out,
  input  logic              alu_zero_out,
  input  logic              alu_pc_skip,
  output logic [15:0]       wreg,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  // Opcodes with sequencing behaviour of their own; 0x0-0x7 are plain ALU ops.
  localparam logic [3:0] OP_LAST_ALU = 4'h7;
  localparam logic [3:0] OP_SKIP_Z   = 4'h9;  // last opcode that reads memory
  localparam logic [3:0] OP_MOVWF    = 4'hA;
  localparam logic [3:0] OP_MOVLW    = 4'hB;
  localparam logic [3:0] OP_GOTO     = 4'hC;
  localparam logic [3:0] OP_HALT     = 4'hF;
  localparam logic [3:0] OP_IDLE     = 4'hF;  // alu_op value outside EXEC

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_wreg;
  logic [15:0]       r_ir;
  logic [15:0]       r_mdr;
  logic              r_carry;
  logic              r_zero;
  logic              r_data_we;
  logic [15:0]       r_data_wdata;
  logic [3:0]        r_alu_op;
  logic              r_halted;

  logic [3:0]        w_dec_op;   // opcode of the word arriving in DECODE
  logic [3:0]        w_ir_op;    // opcode of the latched instruction
  logic [ADDR_W-1:0] w_pc_inc1;
  logic [ADDR_W-1:0] w_pc_inc2;

  assign w_dec_op  = instr_data[15:12];
  assign w_ir_op   = r_ir[15:12];
  // Both increments wrap naturally at the ADDR_W boundary.
  assign w_pc_inc1 = r_pc + ADDR_W'(1);
  assign w_pc_inc2 = r_pc + ADDR_W'(2);

  assign instr_addr   = r_pc;
  assign data_addr    = r_ir[ADDR_W-1:0];
  assign data_we      = r_data_we;
  assign data_wdata   = r_data_wdata;
  assign alu_op       = r_alu_op;
  assign alu_mem      = r_mdr;
  assign alu_wreg     = r_wreg;
  assign alu_carry_in = r_carry;
  assign alu_zero_in  = r_zero;
  assign wreg         = r_wreg;
  assign pc           = r_pc;
  assign halted       = r_halted;

  // NOTE: every register here is updated with non-blocking assignments so
  // that all reads in this block see the values from before the clock edge;
  // mixing in blocking assignments would make ordering inside the block
  // change behaviour and diverge from synthesis.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // data_we is a plain flop cleared here, so a reset in the middle of a
      // write drops the strobe without waiting for a clock edge.
      r_state      <= ST_FETCH;
      r_pc         <= '0;
      r_wreg       <= '0;
      r_ir         <= '0;
      r_mdr        <= '0;
      r_carry      <= 1'b0;
      r_zero       <= 1'b0;
      r_data_we    <= 1'b0;
      r_data_wdata <= '0;
      r_alu_op     <= OP_IDLE;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          // instr_addr already shows pc; the word arrives next cycle.
          r_state <= ST_DECODE;
        end

        ST_DECODE: begin
          r_ir <= instr_data;
          if (w_dec_op <= OP_SKIP_Z) begin
            r_state <= ST_READ;
          end else if (w_dec_op == OP_MOVWF) begin
            r_data_wdata <= r_wreg;
            r_data_we    <= 1'b1;
            r_state      <= ST_WRITE;
          end else if (w_dec_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            // MOVLW, GOTO and the NOPs go straight to EXEC; alu_op is
            // registered so it is loaded on the way in.
            r_alu_op <= w_dec_op;
            r_state  <= ST_EXEC;
          end
        end

        ST_READ: begin
          if (data_ready) begin
            r_mdr    <= data_rdata;
            r_alu_op <= w_ir_op;
            r_state  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_alu_op <= OP_IDLE;
          if (w_ir_op <= OP_LAST_ALU) begin
            r_carry <= alu_carry_out;
            r_zero  <= alu_zero_out;
            r_pc    <= w_pc_inc1;
            if (r_ir[11]) begin
              r_data_wdata <= alu_result;
              r_data_we    <= 1'b1;
              r_state      <= ST_WRITE;
            end else begin
              r_wreg  <= alu_result;
              r_state <= ST_FETCH;
            end
          end else begin
            r_state <= ST_FETCH;
            case (w_ir_op)
              4'h8, OP_SKIP_Z: r_pc   <= alu_pc_skip ? w_pc_inc2 : w_pc_inc1;
              OP_GOTO:         r_pc   <= r_ir[ADDR_W-1:0];
              OP_MOVLW: begin
                r_wreg <= {5'b0, r_ir[10:0]};
                r_pc   <= w_pc_inc1;
              end
              default:         r_pc   <= w_pc_inc1;
            endcase
          end
        end

        ST_WRITE: begin
          if (data_ready) begin
            r_data_we <= 1'b0;
            r_state   <= ST_FETCH;
            // ALU writebacks advanced pc in EXEC; MOVWF never visits EXEC.
            if (w_ir_op == OP_MOVWF) begin
              r_pc <= w_pc_inc1;
            end
          end
        end

        ST_HALT: begin
          // Terminal: nothing changes until reset.
        end

        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
